// File: rtl/read_channel_native_cwf.sv
// Cache line-refill read channel for the native back-end memory port.
// Bursts optionally start at the critical beat and wrap around the line.
module read_channel_native_cwf #(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int WORD_OFF_W = 3,
  parameter int BE_ADDR_W  = FE_ADDR_W,
  parameter int BE_DATA_W  = FE_DATA_W,
  parameter int BE_BYTE_W  = $clog2(BE_DATA_W/8),
  parameter int LINE2MEM_W = WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W),
  parameter int CRIT_FIRST = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       replace_valid,
  input  logic [FE_ADDR_W-BE_BYTE_W-1:0]             replace_addr,
  output logic                                       replace,
  output logic                                       read_valid,
  output logic [(LINE2MEM_W > 0 ? LINE2MEM_W : 1)-1:0] read_addr,
  output logic [BE_DATA_W-1:0]                       read_rdata,
  output logic                                       crit_valid,
  output logic [BE_ADDR_W-1:0]                       mem_addr,
  output logic                                       mem_valid,
  input  logic                                       mem_ready,
  input  logic [BE_DATA_W-1:0]                       mem_rdata
);

  localparam int IW     = (LINE2MEM_W > 0) ? LINE2MEM_W : 1;
  localparam int LINE_W = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] LAST  = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [LINE_W-1:0]    line;
  logic [IW-1:0]        idx;
  logic [FE_ADDR_W-1:0] addr_full;
  logic                 in_burst, beat, last_beat, first_beat, start_req;

  assign in_burst  = (state == BURST);
  assign beat      = in_burst & mem_ready;
  assign start_req = (state == IDLE) & replace_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (replace_valid) state_nxt = BURST;
      BURST:   if (beat && last_beat) state_nxt = LAST;
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      line  <= '0;
    end else begin
      state <= state_nxt;
      if (start_req) line <= replace_addr[FE_ADDR_W-BE_BYTE_W-1:LINE2MEM_W];
    end
  end

  generate
    if (LINE2MEM_W > 0) begin : g_multi
      logic [IW-1:0] start, cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          start <= '0;
          cnt   <= '0;
        end else if (start_req) begin
          start <= (CRIT_FIRST != 0) ? replace_addr[LINE2MEM_W-1:0] : '0;
          cnt   <= '0;
        end else if (beat) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Wrap-around falls out of the natural LINE2MEM_W-bit overflow.
      assign idx        = start + cnt;
      assign last_beat  = (cnt == '1);
      assign first_beat = (cnt == '0);
      assign addr_full  = FE_ADDR_W'({line, idx}) << BE_BYTE_W;
    end else begin : g_single
      assign idx        = '0;
      assign last_beat  = 1'b1;
      assign first_beat = 1'b1;
      assign addr_full  = FE_ADDR_W'(line) << BE_BYTE_W;
    end
  endgenerate

  // mem_valid drops in the same cycle the final beat is accepted.
  assign mem_valid  = in_burst & (~mem_ready | ~last_beat);
  assign mem_addr   = BE_ADDR_W'(addr_full);
  assign replace    = (state != IDLE);
  assign read_valid = beat;
  assign read_addr  = in_burst ? idx : '0;
  assign read_rdata = mem_rdata;
  assign crit_valid = beat & first_beat;

endmodule

// File: tb/tb_read_channel_native_cwf.sv
// Directed bench for the refill channel: wrap, linear, stalls, reset abort,
// back-to-back requests and single-beat wide lines.
module tb_read_channel_native_cwf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rv, mr;
  logic [29:0] ra;
  logic [31:0] rd;

  logic        w_replace, w_rvalid, w_crit, w_mvalid;
  logic [2:0]  w_raddr;
  logic [31:0] w_rdata, w_maddr;

  logic        l_replace, l_rvalid, l_crit, l_mvalid;
  logic [2:0]  l_raddr;
  logic [31:0] l_rdata, l_maddr;

  logic         rv_w, mr_w;
  logic [26:0]  ra_w;
  logic [255:0] rd_w;
  logic         x_replace, x_rvalid, x_crit, x_mvalid;
  logic [0:0]   x_raddr;
  logic [255:0] x_rdata;
  logic [31:0]  x_maddr;

  read_channel_native_cwf #(.CRIT_FIRST(1)) u_wrap (
    .clk(clk), .reset(reset), .replace_valid(rv), .replace_addr(ra),
    .replace(w_replace), .read_valid(w_rvalid), .read_addr(w_raddr),
    .read_rdata(w_rdata), .crit_valid(w_crit), .mem_addr(w_maddr),
    .mem_valid(w_mvalid), .mem_ready(mr), .mem_rdata(rd));

  read_channel_native_cwf #(.CRIT_FIRST(0)) u_lin (
    .clk(clk), .reset(reset), .replace_valid(rv), .replace_addr(ra),
    .replace(l_replace), .read_valid(l_rvalid), .read_addr(l_raddr),
    .read_rdata(l_rdata), .crit_valid(l_crit), .mem_addr(l_maddr),
    .mem_valid(l_mvalid), .mem_ready(mr), .mem_rdata(rd));

  read_channel_native_cwf #(.BE_DATA_W(256)) u_wide (
    .clk(clk), .reset(reset), .replace_valid(rv_w), .replace_addr(ra_w),
    .replace(x_replace), .read_valid(x_rvalid), .read_addr(x_raddr),
    .read_rdata(x_rdata), .crit_valid(x_crit), .mem_addr(x_maddr),
    .mem_valid(x_mvalid), .mem_ready(mr_w), .mem_rdata(rd_w));

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wrap_addr [8] = '{32'h1014, 32'h1018, 32'h101C, 32'h1000,
                                 32'h1004, 32'h1008, 32'h100C, 32'h1010};
  int          wrap_idx  [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
  logic [31:0] lin_addr  [8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                 32'h1010, 32'h1014, 32'h1018, 32'h101C};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int pulses, busy;

  initial begin
    rv = 0; mr = 0; ra = '0; rd = '0;
    rv_w = 0; mr_w = 0; ra_w = '0; rd_w = '0;
    reset = 1'b0;
    #2 mr = 1;
    #1;
    chk("rst_replace", w_replace, 0);
    chk("rst_mvalid", w_mvalid, 0);
    chk("rst_rvalid", w_rvalid, 0);
    chk("rst_crit", w_crit, 0);
    chk("rst_raddr", w_raddr, 0);
    chk("rst_maddr", w_maddr, 0);
    chk("rst_wide_mvalid", x_mvalid, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1; mr = 0;

    // Wrap and linear bursts, mem_ready held high
    next; ra = 30'h405; rv = 1; mr = 1;
    #1;
    chk("idle_mvalid", w_mvalid, 0);
    chk("idle_rvalid", w_rvalid, 0);
    next; rv = 0;
    for (int k = 0; k < 8; k++) begin
      rd = 32'hA000_0000 + k;
      #1;
      chk("wrap_maddr", w_maddr, wrap_addr[k]);
      chk("wrap_raddr", w_raddr, wrap_idx[k]);
      chk("wrap_rvalid", w_rvalid, 1);
      chk("wrap_crit", w_crit, (k == 0));
      chk("wrap_mvalid", w_mvalid, (k != 7));
      chk("wrap_rdata", w_rdata, rd);
      chk("lin_maddr", l_maddr, lin_addr[k]);
      chk("lin_raddr", l_raddr, k);
      chk("lin_crit", l_crit, (k == 0));
      next;
    end
    #1;
    chk("wrap_last_replace", w_replace, 1);
    chk("wrap_last_mvalid", w_mvalid, 0);
    chk("wrap_last_rvalid", w_rvalid, 0);
    next; #1;
    chk("wrap_idle_replace", w_replace, 0);
    chk("wrap_idle_rvalid", w_rvalid, 0);

    // Back-pressure: three stall cycles ahead of every beat
    ra = 30'h405; rv = 1; mr = 0;
    next; rv = 0;
    pulses = 0; busy = 0;
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) begin
        mr = 0; #1;
        chk("bp_stall_mvalid", w_mvalid, 1);
        chk("bp_stall_maddr", w_maddr, wrap_addr[k]);
        chk("bp_stall_rvalid", w_rvalid, 0);
        if (w_mvalid || w_rvalid) busy++;
        next;
      end
      mr = 1; #1;
      chk("bp_beat_maddr", w_maddr, wrap_addr[k]);
      chk("bp_beat_raddr", w_raddr, wrap_idx[k]);
      if (w_rvalid) pulses++;
      if (w_mvalid || w_rvalid) busy++;
      next;
    end
    mr = 0; #1;
    chk("bp_last_replace", w_replace, 1);
    chk("bp_last_mvalid", w_mvalid, 0);
    chk("bp_pulses", pulses, 8);
    chk("bp_busy_cycles", busy, 32);
    next;

    // Reset asserted after three beats
    ra = 30'h405; rv = 1; mr = 1;
    next; rv = 0;
    repeat (3) next;
    #1;
    chk("rst_mid_rvalid_pre", w_rvalid, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_replace", w_replace, 0);
    chk("rst_mid_mvalid", w_mvalid, 0);
    chk("rst_mid_rvalid", w_rvalid, 0);
    chk("rst_mid_crit", w_crit, 0);
    chk("rst_mid_raddr", w_raddr, 0);
    chk("rst_mid_maddr", w_maddr, 0);
    next; reset = 1'b1;
    next; #1;
    chk("rst_post_replace", w_replace, 0);
    chk("rst_post_mvalid", w_mvalid, 0);
    next; #1;
    chk("rst_post_replace2", w_replace, 0);
    chk("rst_post_rvalid2", w_rvalid, 0);
    ra = 30'h402; rv = 1;
    next; rv = 0; #1;
    chk("restart_maddr", w_maddr, 32'h1008);
    chk("restart_raddr", w_raddr, 2);
    chk("restart_crit", w_crit, 1);
    chk("restart_rvalid", w_rvalid, 1);
    repeat (8) next;
    #1;
    chk("restart_last_replace", w_replace, 1);
    chk("restart_last_mvalid", w_mvalid, 0);
    next;

    // Back-to-back: replace_valid held, address changed mid-burst
    ra = 30'h405; rv = 1; mr = 1;
    next; ra = 30'h800;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("b2b_maddr", w_maddr, wrap_addr[k]);
      next;
    end
    #1;
    chk("b2b_last_mvalid", w_mvalid, 0);
    chk("b2b_last_replace", w_replace, 1);
    next; #1;
    chk("b2b_idle_mvalid", w_mvalid, 0);
    chk("b2b_idle_replace", w_replace, 0);
    next; rv = 0; #1;
    chk("b2b_second_mvalid", w_mvalid, 1);
    chk("b2b_second_maddr", w_maddr, 32'h2000);
    chk("b2b_second_raddr", w_raddr, 0);
    chk("b2b_second_crit", w_crit, 1);
    repeat (8) next;
    next; mr = 0;

    // Single-beat wide line
    ra_w = 27'h40; rv_w = 1; mr_w = 0;
    next; rv_w = 0; #1;
    chk("wide_stall_mvalid", x_mvalid, 1);
    chk("wide_stall_rvalid", x_rvalid, 0);
    chk("wide_stall_replace", x_replace, 1);
    chk("wide_stall_maddr", x_maddr, 32'h800);
    next;
    mr_w = 1; rd_w = {8{32'hC0FF_EE00}};
    #1;
    chk("wide_maddr", x_maddr, 32'h800);
    chk("wide_rvalid", x_rvalid, 1);
    chk("wide_raddr", x_raddr, 0);
    chk("wide_crit", x_crit, 1);
    chk("wide_mvalid", x_mvalid, 0);
    chk("wide_rdata", x_rdata[63:0], 64'hC0FF_EE00_C0FF_EE00);
    next; #1;
    chk("wide_last_replace", x_replace, 1);
    chk("wide_last_mvalid", x_mvalid, 0);
    chk("wide_last_rvalid", x_rvalid, 0);
    next; #1;
    chk("wide_idle_replace", x_replace, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/read_channel_native_cwf.md
Name: read_channel_native_cwf

Overview:
Cache line-refill read channel on the native back-end memory interface. It is the parametrised successor of the linear refill channel and adds critical-word-first wrap-around burst ordering, selectable at elaboration. It also adds an early-restart pulse for the critical beat and same-cycle beat indexing. It sits between the cache replacement controller and the back-end memory port, and feeds refill data into the cache data memory.

Parameters:
FE_ADDR_W, 32, front-end byte-address width
FE_DATA_W, 32, front-end word width
WORD_OFF_W, 3, log2 of words per cache line
BE_ADDR_W, FE_ADDR_W, back-end address width
BE_DATA_W, FE_DATA_W, back-end beat width; must be at least FE_DATA_W and a power-of-2 multiple of it
BE_BYTE_W, $clog2(BE_DATA_W/8), byte-offset width of one beat
LINE2MEM_W, WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W), log2 of beats per line (NBEATS = 2^LINE2MEM_W); 0 is legal
CRIT_FIRST, 1, 1 = wrap burst starting at the requested beat; 0 = linear burst from beat 0

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
replace_valid  in  1  refill request, sampled in IDLE only
replace_addr  in  FE_ADDR_W-BE_BYTE_W  miss address [FE_ADDR_W-1:BE_BYTE_W]: line address plus requested beat
replace  out  1  refill in progress
read_valid  out  1  refill beat valid this cycle
read_addr  out  max(LINE2MEM_W,1)  beat index within the line for the current read_rdata
read_rdata  out  BE_DATA_W  refill beat data, equal to mem_rdata
crit_valid  out  1  pulses with the first returned beat (the critical beat when CRIT_FIRST=1)
mem_addr  out  BE_ADDR_W  beat byte address
mem_valid  out  1  request valid
mem_ready  in  1  beat accepted and rdata valid, same cycle
mem_rdata  in  BE_DATA_W  read data

Behaviour:
- Reset (reset=0, async assert, sync deassert): state=IDLE, beat counter=0, latched line/start=0. Outputs: replace=0, mem_valid=0, read_valid=0, crit_valid=0, read_addr=0. mem_addr shows the cleared latch, zero-extended.
- States and transitions:
  - IDLE -> BURST on replace_valid.
  - BURST -> LAST on the accepted handshake of the final beat.
  - LAST -> IDLE unconditionally.
- Entering BURST latches line = replace_addr[FE_ADDR_W-1:BE_BYTE_W+LINE2MEM_W] and start = replace_addr low LINE2MEM_W bits. start is forced to 0 when CRIT_FIRST=0. The counter cnt clears to 0.
- Beat index idx = (start + cnt) mod NBEATS; wrap-around is natural LINE2MEM_W-bit overflow.
- mem_addr = zero-extend {line, idx, BE_BYTE_W zeros}, driven combinationally from the registered state.
- Latency: mem_valid rises on the cycle after replace_valid is sampled.
- BURST outputs:
  - mem_valid=1 every cycle, deasserted in the same cycle as the last beat's mem_ready (mem_valid = ~mem_ready | (cnt != NBEATS-1)).
  - Handshake is mem_valid & mem_ready. On a handshake, cnt increments.
  - read_valid = mem_ready. read_addr = idx, same cycle, unregistered. read_rdata = mem_rdata.
  - crit_valid = mem_ready & (cnt==0).
- replace=1 in BURST and LAST; replace=0 in IDLE.
- LAST: one-cycle tail to let the cache absorb the final write. mem_valid=0, read_valid=0.
- replace_valid is ignored outside IDLE. If it is held high across LAST, a new burst begins on the cycle after returning to IDLE.
- mem_ready outside BURST is ignored: no read_valid, no state change.
- mem_ready stalls hold mem_addr and idx stable.
- LINE2MEM_W=0: single beat, idx fixed at 0, read_addr=0, crit_valid = read_valid. The same FSM applies and the counter logic is removed.
- Reset asserted mid-burst aborts immediately to IDLE with all outputs as at reset. No partial-line completion is signalled.

Test Plan:
- Wrap ordering: CRIT_FIRST=1, 32/32, WORD_OFF_W=3, replace_addr=0x1014>>2, mem_ready=1 constant -> mem_addr sequence 0x1014,0x1018,0x101C,0x1000,0x1004,0x1008,0x100C,0x1010. read_addr sequence 5,6,7,0,1,2,3,4. crit_valid only with beat 5. Eight read_valid, then one LAST cycle with replace=1, then IDLE.
- Linear mode: CRIT_FIRST=0, same request -> mem_addr 0x1000..0x101C in order, read_addr 0..7, crit_valid with beat 0.
- Back-pressure: mem_ready low for 3 cycles before each beat -> mem_valid held, mem_addr stable during stalls. Exactly 8 read_valid pulses. Total burst length 32 cycles, plus LAST.
- Wide beat: BE_DATA_W=256, WORD_OFF_W=3 (LINE2MEM_W=0), replace_addr line 0x40 -> mem_addr=0x800, one read_valid with read_addr=0, crit_valid=1, LAST, IDLE.
- Reset mid-burst: assert reset low after 3 beats of an 8-beat burst -> same cycle replace=0, mem_valid=0, read_valid=0. After release with replace_valid low, the block stays IDLE. A new request restarts from its own start beat.
- Back-to-back requests: replace_valid held high -> second burst's mem_valid rises exactly 2 cycles after the first burst's last handshake. Requests during BURST do not alter mem_addr.
